// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition, E->M register.
// Optional EXEC_PERF_EN adds perf_ops and perf_jmp_nt event counters.
module execute_stage #(
    parameter int         WORD  = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      E_stat,
    input  logic [3:0]      E_icode,
    input  logic [3:0]      E_ifun,
    input  logic [WORD-1:0] E_valC,
    input  logic [WORD-1:0] E_valA,
    input  logic [WORD-1:0] E_valB,
    input  logic [3:0]      E_dstE,
    input  logic [3:0]      E_dstM,
    input  logic [2:0]      m_stat,
    input  logic [2:0]      W_stat,
    input  logic            M_bubble,
    output logic [WORD-1:0] e_valE,
    output logic [3:0]      e_dstE,
    output logic            e_Cnd,
    output logic [2:0]      M_stat,
    output logic [3:0]      M_icode,
    output logic            M_Cnd,
    output logic [WORD-1:0] M_valE,
    output logic [WORD-1:0] M_valA,
    output logic [3:0]      M_dstE,
    output logic [3:0]      M_dstM,
    output logic [2:0]      cc
`ifdef EXEC_PERF_EN
    ,
    output logic [31:0]     perf_ops,
    output logic [31:0]     perf_jmp_nt
`endif
);

    localparam logic [WORD-1:0] EIGHT = WORD'(8);

    logic [WORD-1:0] alu_a;
    logic [WORD-1:0] alu_b;
    logic [WORD-1:0] alu_res;
    logic [3:0]      alu_fun;
    logic            zf_n;
    logic            sf_n;
    logic            of_n;
    logic            set_cc;
    logic            cond;
    logic            zf;
    logic            sf;
    logic            of;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            4'h2, 4'h6:       alu_a = E_valA;
            4'h3, 4'h4, 4'h5: alu_a = E_valC;
            4'h8, 4'hA:       alu_a = '0 - EIGHT;
            4'h9, 4'hB:       alu_a = EIGHT;
            default:          alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            4'h4, 4'h5, 4'h6, 4'h8,
            4'h9, 4'hA, 4'hB: alu_b = E_valB;
            default:          alu_b = '0;
        endcase
    end

    assign alu_fun = (E_icode == 4'h6) ? E_ifun : 4'h0;

    always_comb begin
        alu_res = '0;
        of_n    = 1'b0;
        case (alu_fun)
            4'h0: begin
                alu_res = alu_b + alu_a;
                of_n    = (alu_a[WORD-1] == alu_b[WORD-1])
                       && (alu_res[WORD-1] != alu_a[WORD-1]);
            end
            4'h1: begin
                alu_res = alu_b - alu_a;
                of_n    = (alu_a[WORD-1] != alu_b[WORD-1])
                       && (alu_res[WORD-1] != alu_b[WORD-1]);
            end
            4'h2:    alu_res = alu_b & alu_a;
            4'h3:    alu_res = alu_b ^ alu_a;
            default: alu_res = '0;
        endcase
    end

    assign zf_n   = (alu_res == '0);
    assign sf_n   = alu_res[WORD-1];
    assign e_valE = alu_res;

    // A faulting instruction further down the pipe must not see later flags.
    assign set_cc = (E_icode == 4'h6)
                 && !(m_stat inside {3'd2, 3'd3, 3'd4})
                 && !(W_stat inside {3'd2, 3'd3, 3'd4});

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = ~zf;
            4'h5:    cond = ~(sf ^ of);
            4'h6:    cond = ~(sf ^ of) & ~zf;
            default: cond = 1'b0;
        endcase
    end

    assign e_Cnd  = (E_icode == 4'h2 || E_icode == 4'h7) ? cond : 1'b0;
    assign e_dstE = (E_icode == 4'h2 && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (reset) begin
            cc <= 3'b100;
        end else if (set_cc) begin
            cc <= {zf_n, sf_n, of_n};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || M_bubble) begin
            M_stat  <= 3'd1;
            M_icode <= 4'h1;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

`ifdef EXEC_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops    <= '0;
            perf_jmp_nt <= '0;
        end else begin
            if (set_cc)
                perf_ops <= perf_ops + 32'd1;
            if (E_icode == 4'h7 && !e_Cnd && !M_bubble)
                perf_jmp_nt <= perf_jmp_nt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against a behavioural model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic        M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  cc;
`ifdef EXEC_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_jmp_nt;
    logic [31:0] x_ops;
    logic [31:0] x_jmp;
`endif

    execute_stage dut (
        .clk(clk), .reset(reset),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc(cc)
`ifdef EXEC_PERF_EN
        , .perf_ops(perf_ops), .perf_jmp_nt(perf_jmp_nt)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // model state
    logic [2:0]  mcc;
    logic [2:0]  x_stat;
    logic [3:0]  x_icode;
    logic        x_cnd;
    logic [63:0] x_valE;
    logic [63:0] x_valA;
    logic [3:0]  x_dstE;
    logic [3:0]  x_dstM;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Reference: pick operands from the opcode table, evaluate the operation
    // in 65-bit signed arithmetic to detect overflow.
    task automatic model_comb(output logic [63:0] v, output logic [3:0] d,
                              output logic c, output logic [2:0] fl,
                              output logic sc);
        logic [63:0] a, b;
        logic [64:0] wide;
        logic        o, z, s, l;
        a = 0;
        b = 0;
        o = 0;
        if (E_icode == 2 || E_icode == 6) a = E_valA;
        if (E_icode >= 3 && E_icode <= 5) a = E_valC;
        if (E_icode == 8 || E_icode == 10) a = 64'hFFFF_FFFF_FFFF_FFF8;
        if (E_icode == 9 || E_icode == 11) a = 64'd8;
        if (E_icode >= 4 && E_icode <= 11 && E_icode != 7) b = E_valB;
        if (E_icode != 6 || E_ifun == 0) begin
            wide = {b[63], b} + {a[63], a};
            v = wide[63:0];
            o = wide[64] ^ wide[63];
        end else if (E_ifun == 1) begin
            wide = {b[63], b} - {a[63], a};
            v = wide[63:0];
            o = wide[64] ^ wide[63];
        end else if (E_ifun == 2) v = a & b;
        else if (E_ifun == 3) v = a ^ b;
        else v = 0;
        fl = {v == 0, v[63], o};
        sc = (E_icode == 6) && (m_stat < 2 || m_stat > 4)
                            && (W_stat < 2 || W_stat > 4);
        z = mcc[2];
        l = mcc[1] ^ mcc[0];
        case (E_ifun)
            0: c = 1;
            1: c = l | z;
            2: c = l;
            3: c = z;
            4: c = !z;
            5: c = !l;
            6: c = !l && !z;
            default: c = 0;
        endcase
        if (E_icode != 2 && E_icode != 7) c = 0;
        d = (E_icode == 2 && !c) ? 4'hF : E_dstE;
    endtask

    task automatic drive(input logic rst, input logic [3:0] ic,
                         input logic [3:0] fn, input logic [63:0] vc,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [2:0] ms, input logic [2:0] ws,
                         input logic bub);
        reset = rst;
        E_stat = 3'd1;
        E_icode = ic;
        E_ifun = fn;
        E_valC = vc;
        E_valA = va;
        E_valB = vb;
        E_dstE = de;
        E_dstM = dm;
        m_stat = ms;
        W_stat = ws;
        M_bubble = bub;
    endtask

    // One cycle: check combinational outputs, clock, check registered ones.
    task automatic cyc();
        logic [63:0] v;
        logic [3:0]  d;
        logic        c, sc;
        logic [2:0]  fl;
        #1;
        model_comb(v, d, c, fl, sc);
        chk("e_valE", e_valE, v);
        chk("e_dstE", {60'd0, e_dstE}, {60'd0, d});
        chk("e_Cnd", {63'd0, e_Cnd}, {63'd0, c});
        @(posedge clk);
        if (reset) begin
            mcc = 3'b100;
`ifdef EXEC_PERF_EN
            x_ops = 0;
            x_jmp = 0;
`endif
        end else begin
            if (sc) mcc = fl;
`ifdef EXEC_PERF_EN
            if (sc) x_ops++;
            if (E_icode == 7 && !c && !M_bubble) x_jmp++;
`endif
        end
        if (reset || M_bubble) begin
            x_stat = 1; x_icode = 1; x_cnd = 0; x_valE = 0;
            x_valA = 0; x_dstE = 4'hF; x_dstM = 4'hF;
        end else begin
            x_stat = E_stat; x_icode = E_icode; x_cnd = c; x_valE = v;
            x_valA = E_valA; x_dstE = d; x_dstM = E_dstM;
        end
        #1;
        chk("M_stat", {61'd0, M_stat}, {61'd0, x_stat});
        chk("M_icode", {60'd0, M_icode}, {60'd0, x_icode});
        chk("M_Cnd", {63'd0, M_Cnd}, {63'd0, x_cnd});
        chk("M_valE", M_valE, x_valE);
        chk("M_valA", M_valA, x_valA);
        chk("M_dstE", {60'd0, M_dstE}, {60'd0, x_dstE});
        chk("M_dstM", {60'd0, M_dstM}, {60'd0, x_dstM});
        chk("cc", {61'd0, cc}, {61'd0, mcc});
`ifdef EXEC_PERF_EN
        chk("perf_ops", {32'd0, perf_ops}, {32'd0, x_ops});
        chk("perf_jmp_nt", {32'd0, perf_jmp_nt}, {32'd0, x_jmp});
`endif
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 16));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        mcc = 3'b100;
        drive(1, 1, 0, 0, 0, 0, 4'hF, 4'hF, 1, 1, 0);
        @(negedge clk);
        cyc();
        drive(0, 1, 0, 0, 0, 0, 4'hF, 4'hF, 1, 1, 0);
        cyc();
        chk("rst M_icode", {60'd0, M_icode}, 64'd1);
        chk("rst M_stat", {61'd0, M_stat}, 64'd1);
        chk("rst M_dstE", {60'd0, M_dstE}, 64'hF);
        chk("rst M_dstM", {60'd0, M_dstM}, 64'hF);
        chk("rst cc", {61'd0, cc}, 64'd4);
        chk("rst e_Cnd", {63'd0, e_Cnd}, 64'd0);

        drive(0, 6, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 3, 4'hF, 1, 1, 0);
        cyc();
        chk("add e_valE", e_valE, 64'h8000_0000_0000_0000);
        chk("add cc", {61'd0, cc}, 64'd3);
        chk("add M_valE", M_valE, 64'h8000_0000_0000_0000);

        drive(0, 6, 1, 0, 5, 5, 3, 4'hF, 1, 1, 0);
        cyc();
        chk("sub cc", {61'd0, cc}, 64'd4);
        drive(0, 7, 1, 64'h40, 0, 0, 4'hF, 4'hF, 1, 1, 0);
        cyc();
        chk("jle e_Cnd", {63'd0, e_Cnd}, 64'd1);
        chk("jle M_Cnd", {63'd0, M_Cnd}, 64'd1);
        drive(0, 7, 4, 64'h40, 0, 0, 4'hF, 4'hF, 1, 1, 0);
        cyc();
        chk("jne e_Cnd", {63'd0, e_Cnd}, 64'd0);

        drive(0, 6, 0, 0, 1, 1, 3, 4'hF, 1, 1, 0);
        cyc();
        drive(0, 2, 3, 0, 64'h55, 0, 2, 4'hF, 1, 1, 0);
        cyc();
        chk("cmov nt e_dstE", {60'd0, e_dstE}, 64'hF);
        chk("cmov nt M_dstE", {60'd0, M_dstE}, 64'hF);
        drive(0, 6, 1, 0, 3, 3, 3, 4'hF, 1, 1, 0);
        cyc();
        drive(0, 2, 3, 0, 64'h55, 0, 2, 4'hF, 1, 1, 0);
        cyc();
        chk("cmov t M_dstE", {60'd0, M_dstE}, 64'd2);
        chk("cmov t M_valE", M_valE, 64'h55);

        drive(0, 6, 0, 0, 1, 1, 3, 4'hF, 3, 1, 0);
        cyc();
        chk("m ADR cc", {61'd0, cc}, 64'd4);
        drive(0, 6, 0, 0, 1, 1, 3, 4'hF, 1, 4, 0);
        cyc();
        chk("W INS cc", {61'd0, cc}, 64'd4);
        drive(0, 8, 0, 64'h200, 0, 64'h100, 4, 4'hF, 1, 1, 0);
        #1;
        chk("call e_valE", e_valE, 64'hF8);
        cyc();

        drive(0, 5, 0, 64'h10, 0, 64'h20, 4'hF, 6, 1, 1, 1);
        cyc();
        chk("bubble M_icode", {60'd0, M_icode}, 64'd1);
        chk("bubble M_dstM", {60'd0, M_dstM}, 64'hF);
        drive(1, 6, 0, 0, 1, 1, 3, 4'hF, 1, 1, 1);
        cyc();
        chk("rst cc wins", {61'd0, cc}, 64'd4);
        chk("rst M_valE", M_valE, 64'd0);
`ifdef EXEC_PERF_EN
        chk("rst perf_ops", {32'd0, perf_ops}, 64'd0);
        chk("rst perf_jmp", {32'd0, perf_jmp_nt}, 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 3,
                  4'($urandom_range(0, 99) < 90 ? $urandom_range(0, 11)
                                                : $urandom_range(12, 15)),
                  4'($urandom_range(0, 7)),
                  rnd64(), rnd64(), rnd64(),
                  4'($urandom), 4'($urandom),
                  3'($urandom_range(1, 4)), 3'($urandom_range(1, 4)),
                  $urandom_range(0, 99) < 20);
            E_stat = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4))
                                                 : 3'd1;
            if ($urandom_range(0, 1) == 1) begin
                m_stat = 1;
                W_stat = 1;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
